if_fetch_buf: RTL and testbench
===============================

Name: if_fetch_buf

Overview:
- Fetch stage directly downstream of the PC register.
- Takes the PC stream (pc/ce), issues in-order instruction-memory reads with a req/gnt/rvalid handshake, and buffers {pc, inst} pairs in a small FIFO.
- Presents the pairs to the IF/ID decode side with valid/ready.
- Provides back-pressure to the PC side and supports a same-cycle flush on branch/jump redirects.

Parameters:
ADDR_WIDTH, 32, PC / instruction address width
DATA_WIDTH, 32, instruction width
DEPTH, 4, FIFO entries; power of two, >= 2
MAX_OUTST, 2, maximum granted-but-unanswered memory reads

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-high
pc_i  input  ADDR_WIDTH  fetch address from PC register
ce_i  input  1  pc_i valid (PC register chip-enable)
pc_ready_o  output  1  block accepts pc_i this cycle
flush_i  input  1  redirect: discard all buffered and in-flight fetches
imem_req_o  output  1  memory read request
imem_addr_o  output  ADDR_WIDTH  request address, held stable while imem_req_o=1 and imem_gnt_i=0
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  read data valid; responses return in request order
imem_rdata_i  input  DATA_WIDTH  read data
id_valid_o  output  1  FIFO head valid
id_pc_o  output  ADDR_WIDTH  PC of head instruction
id_inst_o  output  DATA_WIDTH  head instruction
id_ready_i  input  1  decode consumes head when id_valid_o=1

Behaviour:
- Reset, asynchronous, checked at any time: all outputs 0; FIFO pointers, count, outstanding counter, drop counter and request register cleared; FSM forced to IDLE.
- Credits: used = fifo_count + outst + (FSM==REQ). This sum is never allowed to exceed DEPTH.
- pc_ready_o = (FSM==IDLE) && !flush_i && used < DEPTH && outst < MAX_OUTST.
- FSM IDLE: on ce_i && pc_ready_o, register pc_i into the address register and go to REQ. imem_req_o=1 from the next cycle.
- FSM REQ: imem_req_o=1 with the address held. On imem_gnt_i, push the address into the pending-PC queue (depth MAX_OUTST), outst++, and return to IDLE.
- Accepts at most one PC every 2 cycles.
- Response handling: on imem_rvalid_i, pop the pending-PC queue and outst--.
  - If drop counter = 0: push {pc, rdata} into the FIFO.
  - Else: drop counter-- and discard the data.
- Pop: id_valid_o && id_ready_i removes the head. Push and pop in the same cycle are both allowed, including at full.
- id_valid_o = fifo_count != 0. id_pc_o and id_inst_o come directly from the head entry.
- Latency: rvalid at cycle N gives id_valid_o at N+1 (without the bypass option).
- Flush (priority over push/pop/accept):
  - FIFO emptied.
  - Drop counter loaded with outst, minus 1 if a response arrives the same cycle.
  - Pending queue entries are retained so pops stay aligned.
  - A REQ that is not granted this cycle is cancelled (FSM to IDLE, imem_req_o=0 next cycle).
  - A REQ that is granted in the flush cycle counts as in-flight: it is included in the drop counter.
  - pc_ready_o=0 during the flush cycle.
- Pointer wrap is modulo DEPTH. Count width is clog2(DEPTH)+1.
- Boundaries:
  - Full FIFO: no new requests; buffering absorbs all outstanding responses.
  - imem_rvalid_i with outst=0 is a protocol error; the bench asserts on it.

Optional Feature:
- Macro IF_FETCH_BUF_BYPASS_EN.
- Defined: when the FIFO is empty, drop counter=0 and imem_rvalid_i=1, the response drives id_valid_o/id_pc_o/id_inst_o combinationally in the same cycle.
  - If id_ready_i=1 in that cycle, no push occurs.
  - Otherwise the entry is pushed as normal.
- Undefined: outputs are always registered from the FIFO; 1-cycle minimum latency.

Decomposition:
- Shared package/defines: ADDR_WIDTH and DATA_WIDTH defaults, reset PC 32'h0, NOP encoding 32'h00000013, FSM state encodings (IDLE/REQ).
- One natural sub-module: if_fifo, a parameterised synchronous FIFO with async reset, push/pop/flush, full/empty/count.
- Instantiate it twice: once for the {pc, inst} buffer and once (width ADDR_WIDTH, depth MAX_OUTST) for the pending-PC queue.

Test Plan:
- Stream: ce_i=1 with pc 0,4,8,…; gnt immediate; rvalid 1 cycle after gnt; id_ready_i=1 -> decode sees pc 0,4,8 in order with matching rdata; id_valid_o 1 cycle after each rvalid.
- Back-pressure: id_ready_i=0 -> after 4 entries pc_ready_o=0 and imem_req_o stays 0; then id_ready_i=1 -> entries drain in order and fetching resumes.
- Gnt stall: imem_gnt_i=0 for 5 cycles on pc=0x10 -> imem_req_o=1 and imem_addr_o=0x10 stable throughout; exactly one fetch recorded.
- Flush with 2 outstanding: flush_i pulse, then two rvalid -> both discarded, id_valid_o=0; the next fetch of pc=0x100 is delivered.
- Reset mid-operation: assert rst_i asynchronously with 3 FIFO entries -> all outputs 0 immediately, no clock edge needed; after release, fetching restarts cleanly.
- Bypass (IF_FETCH_BUF_BYPASS_EN): empty FIFO, rvalid with rdata=0x00500093 -> id_valid_o=1 in the same cycle and fifo_count stays 0.

Source files
------------

// File: rtl/if_fetch_buf_pkg.sv
// Shared definitions for the instruction fetch buffer.
// Contents: default address/data widths, reset PC, NOP encoding, fetch FSM states.
package if_fetch_buf_pkg;

    localparam int unsigned AddrWidthDef = 32;
    localparam int unsigned DataWidthDef = 32;
    localparam logic [31:0] ResetPc      = 32'h0000_0000;
    localparam logic [31:0] NopInst      = 32'h0000_0013;

    typedef enum logic {
        StIdle = 1'b0,
        StReq  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_buf_fifo.sv
// if_fifo: parameterised synchronous FIFO with asynchronous active-high reset.
// Ports:
//   clk_i, rst_i      clock / async reset
//   flush_i           empties the FIFO; wins over push/pop
//   push_i, wdata_i   write port; push while full is accepted only together with pop
//   pop_i             removes the head (ignored when empty)
//   rdata_o           head entry
//   full_o, empty_o   status
//   count_o           number of stored entries
module if_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // At full the write slot equals the head slot, which is being popped this cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Storage is reset too, so the head output reads 0 after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (do_pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: fetch stage between the PC register and IF/ID.
// Accepts PCs (pc_i/ce_i, pc_ready_o), issues in-order imem reads (req/gnt/rvalid), buffers
// {pc, inst} pairs and presents them to decode (id_valid_o/id_ready_i). flush_i discards
// everything buffered or in flight.
// Ports: clk_i, rst_i (async, active-high); pc_i, ce_i, pc_ready_o; flush_i;
//        imem_req_o, imem_addr_o, imem_gnt_i, imem_rvalid_i, imem_rdata_i;
//        id_valid_o, id_pc_o, id_inst_o, id_ready_i.
// Option: define IF_FETCH_BUF_BYPASS_EN to forward a response straight to decode when the
//         buffer is empty (same-cycle id_valid_o).
module if_fetch_buf
    import if_fetch_buf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = AddrWidthDef,
    parameter int unsigned DATA_WIDTH = DataWidthDef,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_OUTST  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  ce_i,
    output logic                  pc_ready_o,
    input  logic                  flush_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  id_valid_o,
    output logic [ADDR_WIDTH-1:0] id_pc_o,
    output logic [DATA_WIDTH-1:0] id_inst_o,
    input  logic                  id_ready_i
);

    localparam int unsigned CntW  = $clog2(DEPTH) + 1;
    localparam int unsigned OutW  = $clog2(MAX_OUTST) + 1;
    localparam int unsigned PairW = ADDR_WIDTH + DATA_WIDTH;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [OutW-1:0]       outst_q, outst_d;
    logic [OutW-1:0]       drop_q, drop_d;

    logic                  gnt_ok, byp, fifo_push, fifo_pop;
    logic                  fifo_full, fifo_empty, pend_full, pend_empty;
    logic [CntW-1:0]       fifo_count;
    logic [OutW-1:0]       pend_count;
    logic [PairW-1:0]      head;
    logic [ADDR_WIDTH-1:0] pend_pc;
    logic [31:0]           used;

    assign gnt_ok = (state_q == StReq) && imem_gnt_i;

    // Credits: buffered + in flight + the request being presented never exceed DEPTH,
    // so every granted read is guaranteed a buffer slot.
    assign used = 32'(fifo_count) + 32'(outst_q) + 32'(state_q == StReq);

    assign pc_ready_o = !rst_i && (state_q == StIdle) && !flush_i && (used < DEPTH) &&
                        (32'(outst_q) < MAX_OUTST);

    assign imem_req_o  = (state_q == StReq);
    assign imem_addr_o = addr_q;

`ifdef IF_FETCH_BUF_BYPASS_EN
    assign byp = fifo_empty && (drop_q == '0) && imem_rvalid_i && !flush_i && !rst_i;
`else
    assign byp = 1'b0;
`endif

    assign fifo_push = imem_rvalid_i && (drop_q == '0) && !(byp && id_ready_i);
    assign fifo_pop  = !fifo_empty && id_ready_i;

    assign id_valid_o = !fifo_empty || byp;
    assign id_pc_o    = byp ? pend_pc : head[PairW-1:DATA_WIDTH];
    assign id_inst_o  = byp ? imem_rdata_i : head[DATA_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (ce_i && pc_ready_o) begin
                    state_d = StReq;
                    addr_d  = pc_i;
                end
            end
            StReq: begin
                // An ungranted request is cancelled by a flush.
                if (imem_gnt_i || flush_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        outst_d = outst_q + OutW'(gnt_ok) - OutW'(imem_rvalid_i);
        drop_d  = drop_q;
        if (flush_i) begin
            // Every read still unanswered after this cycle, including one granted now.
            drop_d = outst_d;
        end else if (imem_rvalid_i && (drop_q != '0)) begin
            drop_d = drop_q - OutW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= ADDR_WIDTH'(ResetPc);
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    if_fifo #(
        .Width (PairW),
        .Depth (DEPTH)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (fifo_push),
        .wdata_i ({pend_pc, imem_rdata_i}),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Pending PCs survive a flush so that late responses still pop the matching entry.
    if_fifo #(
        .Width (ADDR_WIDTH),
        .Depth (MAX_OUTST)
    ) u_pend (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (1'b0),
        .push_i  (gnt_ok),
        .wdata_i (addr_q),
        .pop_i   (imem_rvalid_i),
        .rdata_o (pend_pc),
        .full_o  (pend_full),
        .empty_o (pend_empty),
        .count_o (pend_count)
    );

    logic unused_status;
    assign unused_status = ^{fifo_full, pend_full, pend_empty, pend_count};

endmodule

// File: tb/tb_if_fetch_buf.sv
module tb_if_fetch_buf;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAX_OUTST = 2;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic [AW-1:0] pc_i = '0;
    logic          ce_i = 1'b0;
    logic          pc_ready_o;
    logic          flush_i = 1'b0;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic          imem_gnt_i = 1'b0;
    logic          imem_rvalid_i = 1'b0;
    logic [DW-1:0] imem_rdata_i = '0;
    logic          id_valid_o;
    logic [AW-1:0] id_pc_o;
    logic [DW-1:0] id_inst_o;
    logic          id_ready_i = 1'b0;

    always #5 clk = ~clk;

    if_fetch_buf #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .MAX_OUTST  (MAX_OUTST)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .pc_i          (pc_i),
        .ce_i          (ce_i),
        .pc_ready_o    (pc_ready_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_valid_o    (id_valid_o),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .id_ready_i    (id_ready_i)
    );

    typedef struct {
        logic [AW-1:0] addr;
        bit            live;
    } mreq_t;
    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
    } exp_t;

    // Reference model: accepted-but-ungranted PCs, granted reads at the memory, and the
    // ordered list of {pc, inst} decode must still see.
    logic [AW-1:0] acc_q[$];
    mreq_t         mem_q[$];
    exp_t          exp_q[$];
    int            buf_cnt = 0;
    int            grants = 0;
    logic [AW-1:0] next_pc = '0;
    bit            prev_stall = 0;
    logic [AW-1:0] prev_addr = '0;

    int checks = 0;
    int errors = 0;
    int p_ce = 0, p_gnt = 0, p_rv = 0, p_rdy = 0, p_fl = 0;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0050_0093;
    endfunction

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: samples at the falling edge, when inputs and outputs are settled.
    always @(negedge clk) begin : monitor
        bit   hs, live_rv, exp_v;
        exp_t e;
        if (!rst_i) begin
            hs      = id_valid_o && id_ready_i && !flush_i;
            live_rv = 0;
            if (imem_rvalid_i) begin
                assert (mem_q.size() != 0) else $error("rvalid with no outstanding read");
                if (mem_q.size() != 0) begin
                    live_rv = mem_q[0].live && !flush_i;
                    void'(mem_q.pop_front());
                end
            end
`ifdef IF_FETCH_BUF_BYPASS_EN
            exp_v = (buf_cnt != 0) || live_rv;
`else
            exp_v = (buf_cnt != 0);
`endif
            chk("id_valid", {63'd0, id_valid_o}, {63'd0, exp_v});
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_delivery", {32'd0, id_pc_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("id_pc", {32'd0, id_pc_o}, {32'd0, e.pc});
                    chk("id_inst", {32'd0, id_inst_o}, {32'd0, e.inst});
                end
            end
            if (buf_cnt == int'(DEPTH)) begin
                chk("full_no_accept", {63'd0, pc_ready_o}, 64'd0);
                chk("full_no_req", {63'd0, imem_req_o}, 64'd0);
            end
            if (prev_stall && imem_req_o) begin
                chk("addr_stable", {32'd0, imem_addr_o}, {32'd0, prev_addr});
            end
            prev_stall = imem_req_o && !imem_gnt_i && !flush_i;
            prev_addr  = imem_addr_o;
            if (imem_req_o && imem_gnt_i) begin
                if (acc_q.size() == 0) begin
                    chk("spurious_grant_req", {32'd0, imem_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("req_addr", {32'd0, imem_addr_o}, {32'd0, acc_q.pop_front()});
                end
                mem_q.push_back('{addr: imem_addr_o, live: 1'b1});
                grants++;
                chk("outst_limit", {63'd0, mem_q.size() > int'(MAX_OUTST)}, 64'd0);
            end
            if (ce_i && pc_ready_o) begin
                acc_q.push_back(pc_i);
                exp_q.push_back('{pc: pc_i, inst: mem_fn(pc_i)});
                next_pc = pc_i + 32'd4;
            end
            buf_cnt = buf_cnt + int'(live_rv) - int'(hs);
            if (flush_i) begin
                chk("flush_no_accept", {63'd0, pc_ready_o}, 64'd0);
                exp_q.delete();
                acc_q.delete();
                foreach (mem_q[i]) mem_q[i].live = 1'b0;
                buf_cnt = 0;
            end
        end
    end

    task automatic drive();
        @(posedge clk);
        #1;
        ce_i       = pct(p_ce);
        pc_i       = next_pc;
        imem_gnt_i = pct(p_gnt);
        if (mem_q.size() != 0 && pct(p_rv)) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_fn(mem_q[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        id_ready_i = pct(p_rdy);
        flush_i    = pct(p_fl);
        if (flush_i) next_pc = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic run(input int n, input int ce, input int gnt, input int rv, input int rdy,
                       input int fl);
        p_ce = ce; p_gnt = gnt; p_rv = rv; p_rdy = rdy; p_fl = fl;
        repeat (n) drive();
    endtask

    task automatic idle_inputs();
        ce_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; id_ready_i = 0; flush_i = 0;
        imem_rdata_i = '0; pc_i = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc_ready"}, {63'd0, pc_ready_o}, 64'd0);
        chk({tag, "_req"}, {63'd0, imem_req_o}, 64'd0);
        chk({tag, "_addr"}, {32'd0, imem_addr_o}, 64'd0);
        chk({tag, "_id_valid"}, {63'd0, id_valid_o}, 64'd0);
        chk({tag, "_id_pc"}, {32'd0, id_pc_o}, 64'd0);
        chk({tag, "_id_inst"}, {32'd0, id_inst_o}, 64'd0);
    endtask

    task automatic clear_model();
        acc_q.delete(); mem_q.delete(); exp_q.delete();
        buf_cnt = 0; prev_stall = 0;
    endtask

    initial begin
        int g0;
        bit filled;
        // Power-on reset.
        #2 rst_i = 1'b1;
        #1 check_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #2 rst_i = 1'b0;

        // Stream: sequential PCs, immediate grant/response, decode always ready.
        next_pc = 32'h0;
        run(40, 100, 100, 100, 100, 0);

        // Back-pressure until full, then drain.
        run(30, 100, 100, 100, 0, 0);
        chk("bp_pc_ready", {63'd0, pc_ready_o}, 64'd0);
        chk("bp_req", {63'd0, imem_req_o}, 64'd0);
        chk("bp_buffered", buf_cnt, DEPTH);
        run(30, 100, 100, 100, 100, 0);
        run(12, 0, 100, 100, 100, 0);

        // Grant stall on pc 0x10.
        next_pc = 32'h10;
        run(1, 100, 0, 100, 100, 0);
        p_ce = 0;
        repeat (5) begin
            drive();
            @(negedge clk);
            chk("stall_req", {63'd0, imem_req_o}, 64'd1);
            chk("stall_addr", {32'd0, imem_addr_o}, 64'h10);
        end
        g0 = grants;
        run(5, 0, 100, 100, 100, 0);
        chk("stall_one_fetch", grants - g0, 1);
        run(12, 0, 100, 100, 100, 0);

        // Flush with two reads outstanding.
        run(6, 100, 100, 0, 100, 0);
        chk("two_outstanding", mem_q.size(), MAX_OUTST);
        run(1, 0, 100, 0, 100, 100);
        next_pc = 32'h100;
        run(4, 0, 100, 100, 100, 0);
        chk("flush_dropped", {63'd0, id_valid_o}, 64'd0);
        chk("flush_queue_empty", exp_q.size(), 0);
        run(10, 100, 100, 100, 100, 0);
        run(12, 0, 100, 100, 100, 0);

        // Asynchronous reset with three buffered entries.
        p_ce = 100; p_gnt = 100; p_rv = 100; p_rdy = 0; p_fl = 0;
        filled = 0;
        for (int i = 0; i < 40 && !filled; i++) begin
            drive();
            if (buf_cnt >= 3) filled = 1;
        end
        chk("fill_three", {63'd0, filled}, 64'd1);
        idle_inputs();
        #2 rst_i = 1'b1;
        #1 check_reset_outputs("async_reset");
        clear_model();
        @(posedge clk); @(posedge clk); #2 rst_i = 1'b0;
        next_pc = 32'h200;
        run(40, 100, 100, 100, 100, 0);
        run(12, 0, 100, 100, 100, 0);

`ifdef IF_FETCH_BUF_BYPASS_EN
        // Bypass: single fetch into an empty buffer, decode ready and stalled.
        next_pc = 32'h300;
        run(8, 100, 100, 100, 100, 0);
        run(12, 0, 100, 100, 100, 0);
        run(8, 100, 100, 100, 0, 0);
        run(12, 0, 100, 100, 100, 0);
`endif

        // Randomized traffic with occasional redirects.
        for (int blk = 0; blk < 15; blk++) begin
            run(200, $urandom_range(30, 100), $urandom_range(20, 100), $urandom_range(20, 100),
                $urandom_range(10, 100), $urandom_range(0, 4));
        end
        run(20, 0, 100, 100, 100, 0);
        chk("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
